// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared types and constants for the oversampling UART receiver.
package uart_rx_pkg;
    typedef enum logic [1:0] {PAR_NONE, PAR_ODD, PAR_EVEN, PAR_NONE2} parity_e;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} rx_state_e;
    localparam int ERR_PAR = 0;
    localparam int ERR_FRM = 1;
    localparam int ERR_BRK = 2;
    localparam int OS_DEFAULT = 16;
endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: synchronous FIFO; a pop frees a slot for a same-cycle push, head reads 0 while empty.
module uart_rx_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             dropped
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count;
    logic full, do_push, do_pop;
    assign full = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    assign do_pop = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dropped = push && !do_push;
    assign dout = empty ? '0 : mem[rd_ptr];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr] <= din;
endmodule

// File: rtl/uart_rx_os.sv
// uart_rx_os: oversampling UART receiver with majority voting, runtime framing config
// and a frame FIFO carrying per-frame parity/framing/break flags.
module uart_rx_os import uart_rx_pkg::*; #(
    parameter int OS = OS_DEFAULT,
    parameter int DIV_W = 16,
    parameter int DATA_MAX = 9,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rx_in,
    input  logic [DIV_W-1:0]    baud_div,
    input  logic [3:0]          data_bits,
    input  logic [1:0]          parity_type,
    input  logic                stop_bits,
    output logic [DATA_MAX-1:0] rx_data,
    output logic [2:0]          rx_err,
    output logic                rx_valid,
    input  logic                rx_ready,
    output logic                overrun,
    input  logic                overrun_clr,
    output logic                busy
);
    localparam int OW = $clog2(OS);
    rx_state_e state, nxt;
    parity_e cfg_par;
    logic s1, s2, prev;
    logic [DIV_W-1:0] div_cnt;
    logic [OW-1:0] os_cnt;
    logic [3:0] cfg_bits, bit_idx, bits_c;
    logic cfg_stop2, v0, v1, perr, ferr, stop_hi, par_zero;
    logic [DATA_MAX-1:0] data_r;
    logic tick, start_det, at_vote, at_end, vote, par_en, push, empty, dropped;
    logic [2:0] err_p;
    logic [DATA_MAX+2:0] head;

    assign bits_c = data_bits < 4'd5 ? 4'd5 : data_bits > 4'(DATA_MAX) ? 4'(DATA_MAX) : data_bits;
    assign tick = div_cnt == '0;
    assign start_det = state == IDLE && prev && !s2;
    assign at_vote = tick && os_cnt == OW'(OS/2+1);
    assign at_end = tick && os_cnt == OW'(OS-1);
    assign vote = (v0 & v1) | (v0 & s2) | (v1 & s2);
    assign par_en = cfg_par == PAR_ODD || cfg_par == PAR_EVEN;
    assign busy = state != IDLE;
    assign rx_valid = !empty;
    assign rx_data = head[DATA_MAX-1:0];
    assign rx_err = head[DATA_MAX+2:DATA_MAX];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) {s1, s2, prev} <= 3'b111;
        else {s1, s2, prev} <= {rx_in, s1, s2};
    end

    // Both counters restart on the start edge so bit sampling is phase-locked to it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            os_cnt <= '0;
        end else if (start_det) begin
            div_cnt <= baud_div;
            os_cnt <= '0;
        end else begin
            div_cnt <= tick ? baud_div : div_cnt - 1'b1;
            if (tick) os_cnt <= os_cnt == OW'(OS-1) ? '0 : os_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= nxt;
    end

    // Frames are pushed at the last stop vote so a following start edge is never missed.
    always_comb begin
        nxt = state;
        push = 1'b0;
        case (state)
            IDLE:   nxt = start_det ? START : IDLE;
            START:  nxt = at_vote && vote ? IDLE : at_end ? DATA : START;
            DATA:   nxt = at_end && bit_idx == cfg_bits ? (par_en ? PARITY : STOP1) : DATA;
            PARITY: nxt = at_end ? STOP1 : PARITY;
            STOP1: begin
                push = at_vote && !cfg_stop2;
                nxt = push ? IDLE : at_end ? STOP2 : STOP1;
            end
            STOP2: begin
                push = at_vote;
                nxt = push ? IDLE : STOP2;
            end
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        err_p = '0;
        err_p[ERR_PAR] = perr;
        err_p[ERR_FRM] = ferr | !vote;
        err_p[ERR_BRK] = data_r == '0 && par_zero && !(stop_hi | vote);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_bits <= '0;
            cfg_par <= PAR_NONE;
            cfg_stop2 <= 1'b0;
            data_r <= '0;
            bit_idx <= '0;
            v0 <= 1'b1;
            v1 <= 1'b1;
            perr <= 1'b0;
            ferr <= 1'b0;
            stop_hi <= 1'b0;
            par_zero <= 1'b1;
        end else begin
            if (start_det) begin
                cfg_bits <= bits_c;
                cfg_par <= parity_e'(parity_type);
                cfg_stop2 <= stop_bits;
                data_r <= '0;
                bit_idx <= '0;
                perr <= 1'b0;
                ferr <= 1'b0;
                stop_hi <= 1'b0;
                par_zero <= 1'b1;
            end
            if (tick && os_cnt == OW'(OS/2-1)) v0 <= s2;
            if (tick && os_cnt == OW'(OS/2)) v1 <= s2;
            if (at_vote) begin
                case (state)
                    DATA: begin
                        data_r[bit_idx] <= vote;
                        bit_idx <= bit_idx + 1'b1;
                    end
                    PARITY: begin
                        perr <= vote != (^data_r ^ (cfg_par == PAR_ODD));
                        par_zero <= !vote;
                    end
                    STOP1, STOP2: begin
                        ferr <= ferr | !vote;
                        stop_hi <= stop_hi | vote;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) overrun <= 1'b0;
        else if (dropped) overrun <= 1'b1;
        else if (overrun_clr) overrun <= 1'b0;
    end

    uart_rx_fifo #(.WIDTH(DATA_MAX+3), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk),
        .rst(rst),
        .push(push),
        .din({err_p, data_r}),
        .pop(rx_ready),
        .dout(head),
        .empty(empty),
        .dropped(dropped)
    );
endmodule

// File: tb/tb_uart_rx_os.sv
// tb_uart_rx_os: table-driven, hand-sequenced and randomized checks of uart_rx_os
// against a frame-level reference model.
module tb_uart_rx_os;
    localparam int OS = 16;
    localparam int DATA_MAX = 9;
    logic clk = 1'b0, rst = 1'b1, rx_in = 1'b1, rx_ready = 1'b0, overrun_clr = 1'b0, stop_bits = 1'b0;
    logic [15:0] baud_div = 16'd3;
    logic [3:0] data_bits = 4'd8;
    logic [1:0] parity_type = 2'd0;
    logic [8:0] rx_data;
    logic [2:0] rx_err;
    logic rx_valid, overrun, busy;
    int n_cmp = 0, n_fail = 0, cyc = 0, t_start = 0, lat = 0;

    typedef struct {
        logic [8:0] d;
        int db;
        int pt;
        logic sb, pbit, s1, s2;
        logic [8:0] ed;
        logic [2:0] ee;
    } vec_t;
    vec_t tbl[13];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_os #(.OS(OS), .DIV_W(16), .DATA_MAX(DATA_MAX), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .rx_in(rx_in), .baud_div(baud_div), .data_bits(data_bits),
        .parity_type(parity_type), .stop_bits(stop_bits), .rx_data(rx_data), .rx_err(rx_err),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .overrun(overrun), .overrun_clr(overrun_clr), .busy(busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    function automatic int nbits(input int db);
        return db < 5 ? 5 : db > DATA_MAX ? DATA_MAX : db;
    endfunction

    function automatic logic par_of(input logic [8:0] d, input int nb, input int pt);
        logic x;
        x = 1'b0;
        for (int i = 0; i < nb; i++) x ^= d[i];
        return pt == 1 ? !x : x;
    endfunction

    function automatic logic [11:0] model(input logic [8:0] d, input int db, input int pt,
                                          input logic sb, input logic pbit, input logic s1, input logic s2);
        int nb;
        logic [8:0] dm;
        logic pen, perr, ferr, brk;
        nb = nbits(db);
        dm = d & 9'((1 << nb) - 1);
        pen = pt == 1 || pt == 2;
        perr = pen && pbit != par_of(dm, nb, pt);
        ferr = !s1 || (sb && !s2);
        brk = dm == 0 && !(pen && pbit) && !s1 && !(sb && s2);
        return {brk, ferr, perr, dm};
    endfunction

    task automatic bits_wait(input int n);
        repeat (n * OS * (int'(baud_div) + 1)) @(negedge clk);
    endtask

    task automatic send(input logic [8:0] d, input int db, input int pt, input logic sb, input logic pbit,
                        input logic s1, input logic s2, input logic [15:0] spike, input bit scr);
        logic q[$];
        int nb, bc;
        nb = nbits(db);
        bc = OS * (int'(baud_div) + 1);
        data_bits = 4'(db);
        parity_type = 2'(pt);
        stop_bits = sb;
        q.push_back(1'b0);
        for (int i = 0; i < nb; i++) q.push_back(d[i]);
        if (pt == 1 || pt == 2) q.push_back(pbit);
        q.push_back(s1);
        if (sb) q.push_back(s2);
        t_start = cyc;
        foreach (q[i]) begin
            for (int c = 0; c < bc; c++) begin
                rx_in = q[i] ^ (spike[i] && c >= 30 && c < 34);
                if (scr && i == 0 && c == 8) begin
                    data_bits = 4'($urandom);
                    parity_type = 2'($urandom);
                    stop_bits = 1'($urandom);
                end
                @(negedge clk);
            end
        end
        rx_in = 1'b1;
    endtask

    task automatic pop_chk(input string name, input logic [8:0] ed, input logic [2:0] ee);
        chk({name, ".valid"}, rx_valid, 1);
        chk({name, ".data"}, rx_data, ed);
        chk({name, ".err"}, rx_err, ee);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0] d;
        logic [11:0] exp;
        int db, pt;
        logic sb, pbit, s1, s2;
        tbl[0]  = '{9'h0A5, 8, 0, 1'b0, 1'b0, 1'b1, 1'b1, 9'h0A5, 3'b000};
        tbl[1]  = '{9'h003, 8, 2, 1'b0, 1'b0, 1'b1, 1'b1, 9'h003, 3'b000};
        tbl[2]  = '{9'h003, 8, 2, 1'b0, 1'b1, 1'b1, 1'b1, 9'h003, 3'b001};
        tbl[3]  = '{9'h07F, 7, 1, 1'b1, 1'b0, 1'b1, 1'b1, 9'h07F, 3'b000};
        tbl[4]  = '{9'h055, 8, 0, 1'b0, 1'b0, 1'b0, 1'b1, 9'h055, 3'b010};
        tbl[5]  = '{9'h1F5, 3, 0, 1'b0, 1'b0, 1'b1, 1'b1, 9'h015, 3'b000};
        tbl[6]  = '{9'h1A5, 15, 0, 1'b0, 1'b0, 1'b1, 1'b1, 9'h1A5, 3'b000};
        tbl[7]  = '{9'h100, 9, 1, 1'b0, 1'b0, 1'b1, 1'b1, 9'h100, 3'b000};
        tbl[8]  = '{9'h000, 8, 0, 1'b0, 1'b0, 1'b1, 1'b1, 9'h000, 3'b000};
        tbl[9]  = '{9'h000, 8, 2, 1'b0, 1'b0, 1'b0, 1'b0, 9'h000, 3'b110};
        tbl[10] = '{9'h00A, 5, 2, 1'b1, 1'b0, 1'b1, 1'b0, 9'h00A, 3'b010};
        tbl[11] = '{9'h000, 8, 2, 1'b0, 1'b1, 1'b0, 1'b1, 9'h000, 3'b011};
        tbl[12] = '{9'h05A, 8, 3, 1'b0, 1'b1, 1'b1, 1'b1, 9'h05A, 3'b000};

        repeat (3) @(negedge clk);
        chk("rst.valid", rx_valid, 0);
        chk("rst.data", rx_data, 0);
        chk("rst.err", rx_err, 0);
        chk("rst.overrun", overrun, 0);
        chk("rst.busy", busy, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        foreach (tbl[i]) begin
            send(tbl[i].d, tbl[i].db, tbl[i].pt, tbl[i].sb, tbl[i].pbit, tbl[i].s1, tbl[i].s2, 16'h0, 1'b0);
            bits_wait(1);
            pop_chk($sformatf("tbl%0d", i), tbl[i].ed, tbl[i].ee);
            chk($sformatf("tbl%0d.empty", i), rx_valid, 0);
        end

        data_bits = 4'd8; parity_type = 2'd0; stop_bits = 1'b0;
        rx_in = 1'b0;
        repeat (4) @(negedge clk);
        rx_in = 1'b1;
        repeat (4) @(negedge clk);
        chk("glitch.busy_on", busy, 1);
        repeat (56) @(negedge clk);
        chk("glitch.busy_off", busy, 0);
        chk("glitch.valid", rx_valid, 0);

        send(9'h0A5, 8, 0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h000C, 1'b0);
        bits_wait(1);
        pop_chk("spike", 9'h0A5, 3'b000);

        rx_in = 1'b0;
        bits_wait(12);
        chk("break.busy", busy, 0);
        pop_chk("break", 9'h000, 3'b110);
        chk("break.single", rx_valid, 0);
        rx_in = 1'b1;
        bits_wait(2);
        chk("break.norestart", rx_valid, 0);
        chk("break.idle", busy, 0);

        for (int k = 0; k < 16; k++) begin
            case ($urandom % 3)
                0: baud_div = 16'd0;
                1: baud_div = 16'd1;
                default: baud_div = 16'd3;
            endcase
            d = 9'($urandom);
            if ($urandom % 5 == 0) d = 9'h0;
            db = int'($urandom_range(15, 3));
            pt = int'($urandom % 4);
            sb = 1'($urandom);
            pbit = par_of(d, nbits(db), pt) ^ ($urandom % 4 == 0);
            s1 = $urandom % 6 != 0;
            s2 = $urandom % 6 != 0;
            exp = model(d, db, pt, sb, pbit, s1, s2);
            send(d, db, pt, sb, pbit, s1, s2, 16'h0, 1'b1);
            bits_wait(1);
            pop_chk($sformatf("rand%0d", k), exp[8:0], exp[11:9]);
            chk($sformatf("rand%0d.empty", k), rx_valid, 0);
        end
        baud_div = 16'd3;
        repeat (4) @(negedge clk);

        fork
            send(9'h011, 8, 0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0, 1'b0);
            begin
                @(negedge clk);
                for (int w = 0; w < 2000 && !rx_valid; w++) @(negedge clk);
                lat = cyc - t_start;
            end
        join
        chk("lat.seen", rx_valid, 1);
        bits_wait(1);
        pop_chk("lat", 9'h011, 3'b000);

        for (int k = 1; k <= 5; k++) send(9'(k), 8, 0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0, 1'b0);
        bits_wait(1);
        chk("ovr.set", overrun, 1);
        overrun_clr = 1'b1;
        @(negedge clk);
        overrun_clr = 1'b0;
        chk("ovr.clr", overrun, 0);

        fork
            send(9'h006, 8, 0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0, 1'b0);
            begin
                @(negedge clk);
                for (int w = 0; w < 4000 && cyc != t_start + lat - 1; w++) @(negedge clk);
                rx_ready = 1'b1;
                @(negedge clk);
                rx_ready = 1'b0;
            end
        join
        bits_wait(1);
        chk("pushpop.ovr", overrun, 0);

        overrun_clr = 1'b1;
        fork
            send(9'h007, 8, 0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0, 1'b0);
            begin
                @(negedge clk);
                for (int w = 0; w < 4000 && cyc != t_start + lat; w++) @(negedge clk);
                overrun_clr = 1'b0;
            end
        join
        chk("ovr.prio", overrun, 1);
        bits_wait(1);
        pop_chk("fifo0", 9'h002, 3'b000);
        pop_chk("fifo1", 9'h003, 3'b000);
        pop_chk("fifo2", 9'h004, 3'b000);
        pop_chk("fifo3", 9'h006, 3'b000);
        chk("fifo.drained", rx_valid, 0);

        send(9'h011, 8, 0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0, 1'b0);
        send(9'h022, 8, 0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0, 1'b0);
        bits_wait(1);
        chk("mid.queued", rx_valid, 1);
        fork
            send(9'h0FF, 8, 0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0, 1'b0);
            begin
                @(negedge clk);
                for (int w = 0; w < 2000 && cyc != t_start + 4 * 64 + 20; w++) @(negedge clk);
                #2 rst = 1'b1;
                #1;
                chk("mid.busy_pre", 32'(busy), 0);
                chk("mid.valid", rx_valid, 0);
                chk("mid.data", rx_data, 0);
                chk("mid.err", rx_err, 0);
                chk("mid.overrun", overrun, 0);
            end
        join
        @(negedge clk);
        rst = 1'b0;
        bits_wait(1);
        chk("post.valid", rx_valid, 0);
        chk("post.busy", busy, 0);
        send(9'h03C, 8, 0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0, 1'b0);
        bits_wait(1);
        pop_chk("post", 9'h03C, 3'b000);
        chk("post.empty", rx_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
